// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that muxes up to N valid/ready requesters onto one registered
// output beat. A grant stays locked to its owner until that owner's last beat is accepted.
module mux_rr_arbiter #(
  parameter int N     = 16,
  parameter int W     = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_last,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_src,
  input  logic             out_ready,
  output logic             locked
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_nxt, owner_q, gnt_idx;
  logic           found, accept, load_en;
  logic [W-1:0]   data_arr [N];

  logic           vld_p1;
  logic [W-1:0]   data_p1;
  logic           last_p1;
  logic [SEL_W-1:0] src_p1;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*W +: W];
  end

  // Stage p0: grant selection, combinational accept strobe
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    if (state_q == LOCKED) begin
      found   = req_valid[owner_q];
      gnt_idx = owner_q;
    end else begin
      // Walk downward so the candidate closest to ptr overwrites the others.
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[IW'((int'(ptr_q) + k) % N)]) begin
          found   = 1'b1;
          gnt_idx = IW'((int'(ptr_q) + k) % N);
        end
      end
    end
  end

  assign load_en   = !vld_p1 || out_ready;
  assign accept    = rst_n && load_en && found;
  assign req_ready = accept ? (N'(1) << gnt_idx) : '0;
  assign ptr_nxt   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        ARB:     if (!req_last[gnt_idx]) state_d = LOCKED;
        LOCKED:  if (req_last[gnt_idx])  state_d = ARB;
        default: state_d = ARB;
      endcase
    end
  end

  // Stage p1: registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      src_p1  <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) vld_p1 <= accept;
      if (accept) begin
        data_p1 <= data_arr[gnt_idx];
        last_p1 <= req_last[gnt_idx];
        src_p1  <= SEL_W'(gnt_idx);
        ptr_q   <= ptr_nxt;
        owner_q <= gnt_idx;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_src   = src_p1;
  assign locked    = (state_q == LOCKED);

endmodule
